// File: rtl/div_unit_pkg.sv
// Shared CPU package: divider FSM encoding and default datapath width.
package div_unit_pkg;
  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// Divider request/result bundle: master issues operands, slave returns hi/lo.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring divide step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;

  always_comb begin
    w_shift = {i_rem, i_bit};
    o_qbit  = (w_shift >= {1'b0, i_dvs});
    // Partial remainder is always below the divisor, so it fits back in WIDTH bits.
    o_rem   = o_qbit ? WIDTH'(w_shift - {1'b0, i_dvs}) : w_shift[WIDTH-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider: WIDTH CALC steps, one FIX cycle, DONE pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r;

  logic             w_accept, w_dvs_zero, w_last, w_qbit;
  logic [WIDTH-1:0] w_rem_nx, w_dvd_mag, w_dvs_mag;

  assign w_accept   = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_dvs_zero = (bus.divisor == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_dvd_mag  = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign w_dvs_mag  = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // r_quo starts as the dividend magnitude; quotient bits shift in from the LSB
  // as dividend bits leave from the MSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_dvs_zero ? DONE : CALC;
      CALC:    if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = w_accept ? (w_dvs_zero ? DONE : CALC) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      if (w_dvs_zero) begin
        r_hi <= bus.dividend;
        r_lo <= '1;
      end else begin
        r_rem   <= '0;
        r_quo   <= w_dvd_mag;
        r_dvs   <= w_dvs_mag;
        r_cnt   <= '0;
        r_neg_q <= bus.sign && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_neg_r <= bus.sign && bus.dividend[WIDTH-1];
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nx;
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == FIX) begin
      r_lo <= r_neg_q ? -r_quo : r_quo;
      r_hi <= r_neg_r ? -r_rem : r_rem;
    end
  end

  assign bus.busy = (r_state == CALC) || (r_state == FIX);
  assign bus.done = (r_state == DONE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signs, divide-by-zero, overflow, restart, reset.
module tb_div_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle N: drive start; returns one cycle later (N+1) with start released.
  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sign = sgn; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Starting in cycle N+1, find the done cycle; bounded so a dead DUT cannot hang.
  task automatic wait_done(output int lat, output int busy_cnt, output logic busy_at_done);
    lat = -1; busy_cnt = 0; busy_at_done = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k; busy_at_done = bus.busy;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.sign = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bc; logic bd;
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc, bd);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL u100_7_latency got %0d want 34", lat); end
    n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL u100_7_busy_cycles got %0d want 33", bc); end
    n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL u100_7_busy_at_done got %b want 0", bd); end
    n_cmp++; if (bus.lo !== 32'd14) begin n_bad++; $display("FAIL u100_7_lo got %h want %h", bus.lo, 32'd14); end
    n_cmp++; if (bus.hi !== 32'd2) begin n_bad++; $display("FAIL u100_7_hi got %h want %h", bus.hi, 32'd2); end
    // 0xFFFFFFF9 unsigned = 4294967289; /2 -> 2147483644 rem 1
    launch(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bc, bd);
    n_cmp++; if (bus.lo !== 32'h7FFF_FFFC) begin n_bad++; $display("FAIL u_big_2_lo got %h want 7ffffffc", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_bad++; $display("FAIL u_big_2_hi got %h want 1", bus.hi); end
  endtask

  task automatic test_signed();
    int lat, bc; logic bd;
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bc, bd);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL s_m7_2_latency got %0d want 34", lat); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL s_m7_2_lo got %h want fffffffd", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL s_m7_2_hi got %h want ffffffff", bus.hi); end
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, bc, bd);
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL s_7_m2_lo got %h want fffffffd", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd1) begin n_bad++; $display("FAIL s_7_m2_hi got %h want 1", bus.hi); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic bd;
    launch(1'b0, 32'd5, 32'd0);
    wait_done(lat, bc, bd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL u_5_0_latency got %0d want 1", lat); end
    n_cmp++; if (bc !== 0 || bd !== 1'b0) begin n_bad++; $display("FAIL u_5_0_busy got cnt=%0d done_busy=%b want 0/0", bc, bd); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL u_5_0_lo got %h want ffffffff", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd5) begin n_bad++; $display("FAIL u_5_0_hi got %h want 5", bus.hi); end
    launch(1'b1, 32'd5, 32'd0);
    wait_done(lat, bc, bd);
    n_cmp++; if (lat !== 1 || bc !== 0) begin n_bad++; $display("FAIL s_5_0_timing got lat=%0d busy=%0d want 1/0", lat, bc); end
    n_cmp++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5) begin n_bad++; $display("FAIL s_5_0_result got hi=%h lo=%h want 5/ffffffff", bus.hi, bus.lo); end
    launch(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat, bc, bd);
    n_cmp++; if (bus.hi !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL s_m5_0_hi got %h want fffffffb", bus.hi); end
  endtask

  task automatic test_overflow();
    int lat, bc; logic bd;
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc, bd);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL s_min_m1_latency got %0d want 34", lat); end
    n_cmp++; if (bus.lo !== 32'h8000_0000) begin n_bad++; $display("FAIL s_min_m1_lo got %h want 80000000", bus.lo); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL s_min_m1_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_back_to_back();
    int early_done = 0;
    int lo_changed = 0;
    int second_done = -1;
    launch(1'b0, 32'd100, 32'd7);
    // Now in cycle N+1; step cycles N+2 .. N+34.
    for (int c = 2; c <= 34; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 5) || (c == 34);
      if (c == 5) begin bus.sign = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd3; end
      if (c == 34) begin bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd9; end
      @(negedge clk);
      if (c < 34 && bus.done === 1'b1) early_done++;
    end
    n_cmp++; if (early_done !== 0) begin n_bad++; $display("FAIL b2b_early_done got %0d want 0", early_done); end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got %b want 1", bus.done); end
    n_cmp++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_bad++; $display("FAIL b2b_first_result got hi=%h lo=%h want 2/e", bus.hi, bus.lo); end
    // Second divide accepted in cycle 34; its DONE lands in cycle 68.
    for (int c = 35; c <= 80; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.done === 1'b1) begin second_done = c; break; end
      if (bus.lo !== 32'd14 || bus.hi !== 32'd2) lo_changed++;
    end
    n_cmp++; if (second_done !== 68) begin n_bad++; $display("FAIL b2b_second_done_cycle got %0d want 68", second_done); end
    n_cmp++; if (lo_changed !== 0) begin n_bad++; $display("FAIL b2b_result_hold got %0d changed cycles want 0", lo_changed); end
    n_cmp++; if (bus.lo !== 32'd111 || bus.hi !== 32'd1) begin n_bad++; $display("FAIL b2b_second_result got hi=%h lo=%h want 1/6f", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    // Cycle N+10: reset together with a start that must lose.
    rst = 1'b1;
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_bad++; $display("FAIL rst_mid_hilo got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray_done++;
    end
    n_cmp++; if (stray_done !== 0) begin n_bad++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", stray_done); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
